// File: rtl/tt_um_gate_arbiter_if.sv
// Pin bundle for tt_um_gate_arbiter. It carries the standard Tiny Tapeout
// user-project pins except clk and rst_n.
//   ena     enable; when low, the arbiter state holds
//   ui_in   [3:0] request lines, [7:4] ignored
//   uio_in  operand pairs: a_i = uio_in[2i], b_i = uio_in[2i+1]
//   uo_out  {idx[1:0], valid, result, grant[3:0]}
//   uio_oe  output enables for the uio pins (always 0)
//   uio_out uio output values (always 0)
// The arbiter connects through the slave modport and the driving
// environment through the master modport.
interface tt_um_gate_arbiter_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_oe;
  logic [7:0] uio_out;

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_oe, uio_out
  );

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_oe, uio_out
  );
endinterface

// File: rtl/tt_um_gate_arbiter.sv
// Round-robin arbiter that shares one registered 2-input AND unit among
// four requesters using a 4-phase req/grant handshake.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pin bundle (slave side): ena, ui_in, uio_in in; uo_out, uio_oe,
//          uio_out out
// Every uo_out bit comes straight from a register.
//
// state | meaning
// IDLE  | waiting for any request; picks a winner starting at ptr
// EVAL  | one cycle: registers a_idx & b_idx and raises valid
// DONE  | result held valid until req[idx] drops, then ptr moves past idx
module tt_um_gate_arbiter (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_um_gate_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] idx_q,   idx_d;
  logic [1:0] ptr_q,   ptr_d;
  logic       result_q, result_d;
  logic       valid_q,  valid_d;

  logic [3:0] req;
  logic       found;
  logic [1:0] win;
  logic [1:0] cand;
  logic       op_a, op_b;
  logic       unused_bits;

  assign req         = bus.ui_in[3:0];
  assign unused_bits = &{1'b0, bus.ui_in[7:4]};
  assign op_a        = bus.uio_in[{idx_q, 1'b0}];
  assign op_b        = bus.uio_in[{idx_q, 1'b1}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 4'd0;
      idx_q    <= 2'd0;
      ptr_q    <= 2'd0;
      result_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (bus.ena) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    valid_d  = valid_q;
    found    = 1'b0;
    win      = ptr_q;
    cand     = ptr_q;

    // Scan ptr, ptr+1, ptr+2, ptr+3; the 2-bit sum wraps modulo 4.
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = 4'b0001 << win;
          idx_d   = win;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // Runs to completion even if the requester already withdrew.
        result_d = op_a & op_b;
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        // result is left as is; valid alone qualifies it.
        if (!req[idx_q]) begin
          grant_d = 4'd0;
          valid_d = 1'b0;
          ptr_d   = idx_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.uo_out  = {idx_q, valid_q, result_q, grant_q};
  assign bus.uio_oe  = 8'h00;
  assign bus.uio_out = 8'h00;

endmodule

// File: tb/tb_tt_um_gate_arbiter.sv
module tb_tt_um_gate_arbiter;

  logic clk;
  logic rst_n;
  tt_um_gate_arbiter_if bus ();

  tt_um_gate_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic mon_on = 1'b0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%h expected=scoreboard_entry", tag, bus.uo_out);
    end else begin
      exp = sb.pop_front();
      check(tag, bus.uo_out, exp);
    end
  endtask

  // Full transaction: drive req/operands, expect grant after one edge and
  // valid after the next, hold two cycles, then withdraw req[ei].
  task automatic txn(input logic [3:0] req, input logic [1:0] ei, input logic [7:0] ops);
    logic       r;
    logic [3:0] oh;
    r  = ops[{ei, 1'b0}] & ops[{ei, 1'b1}];
    oh = 4'b0001 << ei;
    bus.ui_in  = {4'h0, req};
    bus.uio_in = ops;
    sb.push_back({ei, 1'b1, r, oh});
    step();
    check("grant", {bus.uo_out[7:5], 1'b0, bus.uo_out[3:0]}, {ei, 1'b0, 1'b0, oh});
    step();
    pop_check("valid");
    step();
    step();
    check("hold", bus.uo_out, {ei, 1'b1, r, oh});
    bus.ui_in[ei] = 1'b0;
    step();
    check("release", bus.uo_out, {ei, 1'b0, r, 4'b0000});
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("uio_oe", bus.uio_oe, 8'h00);
      check("uio_out", bus.uio_out, 8'h00);
      check("onehot", {7'd0, $countones(bus.uo_out[3:0]) <= 1}, 8'h01);
    end
  end

  initial begin
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    #12;
    check("reset_uo", bus.uo_out, 8'h00);
    mon_on = 1'b1;
    rst_n  = 1'b1;
    step();
    check("idle_noreq", bus.uo_out, 8'h00);

    // All four requesting: order 0,1,2,3,0.
    txn(4'b1111, 2'd0, 8'b00_00_00_11);
    txn(4'b1111, 2'd1, 8'b00_00_10_00);
    txn(4'b1111, 2'd2, 8'b00_11_00_00);
    txn(4'b1111, 2'd3, 8'b01_00_00_00);
    txn(4'b1111, 2'd0, 8'b00_00_00_01);

    // Single requester 2, result 1 then 0 (ptr ends at 3).
    txn(4'b0100, 2'd2, 8'h30);
    txn(4'b0100, 2'd2, 8'h10);

    // Wrap: ptr=3 so 3 wins over 1; then ptr wraps to 0.
    txn(4'b1010, 2'd3, 8'hC4);
    txn(4'b0010, 2'd1, 8'hC4);
    txn(4'b1000, 2'd3, 8'hC0);
    txn(4'b0011, 2'd0, 8'h03);
    txn(4'b0010, 2'd1, 8'h0C);

    // Operand changes in DONE do not disturb result.
    bus.ui_in  = 8'h04;
    bus.uio_in = 8'h30;
    step();
    step();
    check("stab_valid", bus.uo_out, 8'hB4);
    for (int v = 0; v < 256; v++) begin
      bus.uio_in = 8'(v);
      step();
      check("stab_hold", bus.uo_out, 8'hB4);
    end
    bus.ui_in = 8'h00;
    step();
    check("stab_release", bus.uo_out, 8'h90);

    // Early drop during EVAL: valid lasts exactly one cycle.
    bus.ui_in  = 8'h08;
    bus.uio_in = 8'hC0;
    step();
    check("early_grant", bus.uo_out, 8'hD8);
    bus.ui_in = 8'h00;
    step();
    check("early_valid", bus.uo_out, 8'hF8);
    step();
    check("early_release", bus.uo_out, 8'hD0);
    step();
    check("early_idle", bus.uo_out, 8'hD0);

    // ena freeze while in EVAL.
    bus.ui_in  = 8'h01;
    bus.uio_in = 8'h03;
    step();
    check("frz_grant", bus.uo_out, 8'h11);
    bus.ena = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("frz_hold", bus.uo_out, 8'h11);
    end
    bus.ena = 1'b1;
    step();
    check("frz_resume", bus.uo_out, 8'h31);

    // Asynchronous reset in DONE, then req3 held.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", bus.uo_out, 8'h00);
    bus.ui_in = 8'h08;
    #2;
    rst_n = 1'b1;
    step();
    check("rst_regrant", bus.uo_out, 8'hC8);
    step();
    check("rst_valid", bus.uo_out, 8'hE8);
    bus.ui_in = 8'h00;
    step();
    check("rst_release", bus.uo_out, 8'hC0);

    // Make ptr nonzero, reset in DONE, and confirm the scan restarts at 0.
    txn(4'b0010, 2'd1, 8'h0C);
    bus.ui_in  = 8'h04;
    bus.uio_in = 8'h30;
    step();
    step();
    check("ptr_pre", bus.uo_out, 8'hB4);
    #3;
    rst_n = 1'b0;
    #1;
    check("ptr_rst_async", bus.uo_out, 8'h00);
    bus.ui_in = 8'h09;
    #2;
    rst_n = 1'b1;
    step();
    check("ptr_reset_grant", bus.uo_out, 8'h01);

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
